// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant and encoded index; owner keeps the grant until done or request drop.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module rr_grant_arbiter #(
   parameter int N        = 8,
   parameter int IDX_W    = 3,
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             done,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   generate
      if (N < 2 || N > 8 || (1 << IDX_W) < N || MAX_HOLD < 1) begin : g_bad_cfg
         $error("rr_grant_arbiter: illegal N/IDX_W/MAX_HOLD combination");
      end
   endgenerate

   state_t           state_q, state_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             vld_q, vld_d;
   logic             tmo_q, tmo_d;
   logic             sel_found;
   logic [IDX_W-1:0] sel_idx;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_HOLD + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   // Scan from the far end back toward ptr so the closest requester wins.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(ptr_q) + k) % N]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'((int'(ptr_q) + k) % N);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      vld_d   = vld_q;
      tmo_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (sel_found) begin
               gnt_d          = '0;
               gnt_d[sel_idx] = 1'b1;
               idx_d          = sel_idx;
               vld_d          = 1'b1;
               state_d        = GRANT;
`ifdef ARB_TIMEOUT_EN
               cnt_d          = '0;
`endif
            end
         end
         GRANT: begin
            if (done || !req[idx_q]) begin
               gnt_d   = '0;
               idx_d   = '0;
               vld_d   = 1'b0;
               ptr_d   = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
               state_d = IDLE;
`ifdef ARB_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
               // counter has seen MAX_HOLD-1 holding edges; this edge ends the MAX_HOLD-th grant cycle
               gnt_d   = '0;
               idx_d   = '0;
               vld_d   = 1'b0;
               ptr_d   = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
               state_d = IDLE;
               tmo_d   = 1'b1;
            end else begin
               cnt_d   = cnt_q + 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         vld_q   <= 1'b0;
         tmo_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         vld_q   <= vld_d;
         tmo_q   <= tmo_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = idx_q;
   assign gnt_valid = vld_q;
`ifdef ARB_TIMEOUT_EN
   assign timeout   = tmo_q;
`else
   assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed plus randomized checks of rr_grant_arbiter against an owner/pointer reference model.
module tb_rr_grant_arbiter;
   localparam int N        = 8;
   localparam int IDX_W    = 3;
   localparam int MAX_HOLD = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     req;
   logic             done;
   logic [N-1:0]     gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_valid;
   logic             timeout;

   int checks = 0;
   int errors = 0;

   // reference model: who owns the resource, where priority starts, how long the grant has been visible
   int   owner = -1;
   int   ptr   = 0;
   int   held  = 0;
   logic exp_tmo = 1'b0;

   rr_grant_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done),
      .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      owner   = -1;
      ptr     = 0;
      held    = 0;
      exp_tmo = 1'b0;
   endtask

   task automatic model_edge();
      bit rel;
      int order[$];
      exp_tmo = 1'b0;
      if (owner < 0) begin
         for (int k = 0; k < N; k++) order.push_back((ptr + k) % N);
         foreach (order[i]) begin
            if (owner < 0 && req[order[i]]) begin
               owner = order[i];
               held  = 1;
            end
         end
      end else begin
         rel = done || !req[owner];
`ifdef ARB_TIMEOUT_EN
         if (!rel && held == MAX_HOLD) begin
            rel     = 1'b1;
            exp_tmo = 1'b1;
         end
`endif
         if (rel) begin
            ptr   = (owner + 1) % N;
            owner = -1;
         end else begin
            held++;
         end
      end
   endtask

   task automatic check_outs(input string tag);
      logic [N-1:0]     eg;
      logic [IDX_W-1:0] ei;
      eg = '0;
      ei = '0;
      if (owner >= 0) begin
         eg[owner] = 1'b1;
         ei        = IDX_W'(owner);
      end
      checks++;
      assert (gnt === eg) else begin
         errors++;
         $error("FAIL %s gnt got %h exp %h", tag, gnt, eg);
      end
      checks++;
      assert (gnt_idx === ei) else begin
         errors++;
         $error("FAIL %s gnt_idx got %0d exp %0d", tag, gnt_idx, ei);
      end
      checks++;
      assert (gnt_valid === (owner >= 0)) else begin
         errors++;
         $error("FAIL %s gnt_valid got %b exp %b", tag, gnt_valid, owner >= 0);
      end
      checks++;
      assert (timeout === exp_tmo) else begin
         errors++;
         $error("FAIL %s timeout got %b exp %b", tag, timeout, exp_tmo);
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_outs(tag);
   endtask

   task automatic expect_gnt(input string tag, input logic [N-1:0] g);
      checks++;
      assert (gnt === g) else begin
         errors++;
         $error("FAIL %s gnt got %h exp %h", tag, gnt, g);
      end
   endtask

   initial begin
      // reset with every requester asking
      rst_n = 1'b0;
      req   = 8'hFF;
      done  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset");
      rst_n = 1'b1;
      tick("post_reset");
      expect_gnt("post_reset_first", 8'h01);

      // full rotation 0..7,0 with done one cycle after each grant
      for (int i = 0; i < 9; i++) begin
         if (i > 0) tick("rr_grant");
         checks++;
         assert (gnt_idx === IDX_W'(i % N)) else begin
            errors++;
            $error("FAIL rr_order idx got %0d exp %0d", gnt_idx, i % N);
         end
         done = 1'b1;
         tick("rr_release");
         done = 1'b0;
      end
      req = '0;
      tick("rr_drain");

      // gaps with wrap: set ptr to 3 by granting and dropping idx 2
      req = 8'h04;
      tick("gap_setup_g");
      req = 8'h00;
      tick("gap_setup_r");
      req = 8'h84;
      tick("gap_first");
      expect_gnt("gap_first_7", 8'h80);
      done = 1'b1;
      tick("gap_release");
      done = 1'b0;
      tick("gap_second");
      expect_gnt("gap_second_2", 8'h04);
      req = '0;
      tick("gap_drain");

      // hold idx 5 while others toggle, then drop it
      req = 8'h20;
      tick("hold_grant");
      for (int i = 0; i < 10; i++) begin
         req = N'($urandom) | 8'h20;
         tick("hold_toggle");
         expect_gnt("hold_stays_5", 8'h20);
      end
      req = '0;
      tick("hold_drop");
      expect_gnt("hold_drop_zero", 8'h00);
      req = 8'hFF;
      tick("hold_next_ptr6");
      expect_gnt("hold_next_6", 8'h40);
      req = '0;
      tick("hold_drain");

      // asynchronous reset while idx 4 owns the grant
      req = 8'h10;
      tick("areset_grant");
      expect_gnt("areset_pre", 8'h10);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outs("areset_immediate");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick("areset_regrant");
      expect_gnt("areset_regrant_4", 8'h10);
      req = '0;
      tick("areset_drain");

`ifdef ARB_TIMEOUT_EN
      req = 8'h08;
      tick("tmo_grant");
      req = 8'h18;
      for (int i = 0; i < MAX_HOLD - 1; i++) tick("tmo_hold");
      expect_gnt("tmo_still_3", 8'h08);
      tick("tmo_release");
      checks++;
      assert (timeout === 1'b1) else begin
         errors++;
         $error("FAIL tmo_pulse timeout got %b exp 1", timeout);
      end
      tick("tmo_next");
      expect_gnt("tmo_next_4", 8'h10);
      req = '0;
      tick("tmo_drain");
`endif

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) req = N'($urandom);
         done = ($urandom_range(0, 4) == 0);
         tick("random");
      end
      req  = '0;
      done = 1'b0;
      tick("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
